// File: rtl/det3_seq_if.sv
// Streaming port bundle for det3_seq: element input channel and determinant
// result channel, both valid/ready.
interface det3_seq_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [3*W+2:0] out_det;
    logic           out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_det, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_det, out_zero
    );
endinterface

// File: rtl/det3_seq.sv
// Sequential 3x3 determinant engine: loads nine row-major elements, expands by
// cofactors through one shared multiplier, then holds the result until taken.
module det3_seq #(
    parameter int W      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    det3_seq_if.slave io,
    output logic      busy
);
    localparam int MW = 2 * W + 2;
    localparam int AW = 3 * W + 3;

    typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [3:0]           step;
    logic [W-1:0]         elem [9];
    logic signed [MW-1:0] m0, m1, m2;
    logic signed [AW-1:0] acc;
    logic signed [W:0]    mul_x;
    logic signed [MW-1:0] mul_y;
    logic signed [AW-1:0] prod;

    function automatic logic signed [W:0] ext(input logic [W-1:0] v);
        return SIGNED ? {v[W-1], v} : {1'b0, v};
    endfunction

    function automatic logic signed [MW-1:0] wide(input logic signed [W:0] v);
        return {{(W+1){v[W]}}, v};
    endfunction

    // NOTE: element slots carry no reset; every slot is rewritten before CALC reads it.
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && io.in_valid)
            elem[cnt] <= io.in_data;
    end

    // Operand select per step; slots are a0 b1 c2 d3 e4 f5 g6 h7 i8.
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (step)
            4'd0: begin mul_x = ext(elem[4]); mul_y = wide(ext(elem[8])); end
            4'd1: begin mul_x = ext(elem[5]); mul_y = wide(ext(elem[7])); end
            4'd2: begin mul_x = ext(elem[3]); mul_y = wide(ext(elem[8])); end
            4'd3: begin mul_x = ext(elem[5]); mul_y = wide(ext(elem[6])); end
            4'd4: begin mul_x = ext(elem[3]); mul_y = wide(ext(elem[7])); end
            4'd5: begin mul_x = ext(elem[4]); mul_y = wide(ext(elem[6])); end
            4'd6: begin mul_x = ext(elem[0]); mul_y = m0; end
            4'd7: begin mul_x = ext(elem[1]); mul_y = m1; end
            4'd8: begin mul_x = ext(elem[2]); mul_y = m2; end
            default: ;
        endcase
    end

    assign prod = AW'(mul_x) * AW'(mul_y);

    // NOTE: all state and registered outputs use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            cnt          <= '0;
            step         <= '0;
            m0           <= '0;
            m1           <= '0;
            m2           <= '0;
            acc          <= '0;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_det   <= '0;
            io.out_zero  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (io.in_valid) begin
                        if (cnt == 4'd8) begin
                            cnt         <= '0;
                            step        <= '0;
                            state       <= CALC;
                            io.in_ready <= 1'b0;
                            busy        <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                CALC: begin
                    step <= step + 4'd1;
                    case (step)
                        4'd0: m0  <= prod[MW-1:0];
                        4'd1: m0  <= m0 - prod[MW-1:0];
                        4'd2: m1  <= prod[MW-1:0];
                        4'd3: m1  <= m1 - prod[MW-1:0];
                        4'd4: m2  <= prod[MW-1:0];
                        4'd5: m2  <= m2 - prod[MW-1:0];
                        4'd6: acc <= prod;
                        4'd7: acc <= acc - prod;
                        4'd8: acc <= acc + prod;
                        // Extra step registers the finished sum onto the output port.
                        4'd9: begin
                            io.out_det   <= acc;
                            io.out_zero  <= (acc == '0);
                            io.out_valid <= 1'b1;
                            step         <= '0;
                            state        <= DONE;
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_det3_seq.sv
// Bench for det3_seq: an unsigned and a signed instance share one stimulus
// stream and are compared against a direct Sarrus-rule determinant.
module tb_det3_seq;
    typedef logic [8:0][3:0] mat_t;
    typedef struct {
        string       name;
        mat_t        m;
        bit          sgn;
        logic [14:0] exp;
        int          gap;
        int          hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;
    logic       busy_u, busy_s;
    int         checks = 0;
    int         errors = 0;

    det3_seq_if #(.W(4)) bus_u ();
    det3_seq_if #(.W(4)) bus_s ();

    assign bus_u.in_valid  = in_valid;
    assign bus_u.in_data   = in_data;
    assign bus_u.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_data   = in_data;
    assign bus_s.out_ready = out_ready;

    det3_seq #(.W(4), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .io(bus_u), .busy(busy_u));
    det3_seq #(.W(4), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .io(bus_s), .busy(busy_s));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic mat_t mk(input int a, b, c, d, e, f, g, h, i);
        mat_t r;
        r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c);
        r[3] = 4'(d); r[4] = 4'(e); r[5] = 4'(f);
        r[6] = 4'(g); r[7] = 4'(h); r[8] = 4'(i);
        return r;
    endfunction

    function automatic vec_t mv(input string n, input mat_t m, input bit s,
                                input logic [14:0] e, input int g, input int h);
        vec_t v;
        v.name = n; v.m = m; v.sgn = s; v.exp = e; v.gap = g; v.hold = h;
        return v;
    endfunction

    // Reference: rule of Sarrus on integers, truncated to the 15-bit port.
    function automatic logic [14:0] model(input mat_t m, input bit sgn);
        int v [9];
        int det;
        for (int k = 0; k < 9; k++)
            v[k] = (sgn && m[k][3]) ? int'(m[k]) - 16 : int'(m[k]);
        det = v[0]*v[4]*v[8] + v[1]*v[5]*v[6] + v[2]*v[3]*v[7]
            - v[2]*v[4]*v[6] - v[1]*v[3]*v[8] - v[0]*v[5]*v[7];
        return 15'(det);
    endfunction

    task automatic send(input mat_t m, input int n, input int gap);
        int k = 0;
        int guard = 0;
        bit take;
        while (k < n && guard < 500) begin
            in_valid = !(gap > 0 && int'($urandom_range(99)) < gap);
            in_data  = in_valid ? m[k] : 4'($urandom_range(15));
            take     = in_valid && bus_u.in_ready;
            @(posedge clk); #1;
            if (take) k++;
            guard++;
        end
        in_valid = 1'b0;
        check("elements accepted", k, n);
    endtask

    task automatic do_one(input string name, input mat_t m, input logic [14:0] eu,
                          input logic [14:0] es, input int gap, input int hold);
        int lat = 0;
        out_ready = (hold == 0);
        send(m, 9, gap);
        check({name, " busy after load"}, {busy_u, busy_s, bus_u.in_ready}, 3'b110);
        for (int t = 1; t <= 40 && lat == 0; t++) begin
            @(posedge clk); #1;
            if (bus_u.out_valid) lat = t;
        end
        check({name, " latency"}, lat, 10);
        check({name, " signed valid"}, bus_s.out_valid, 1'b1);
        check({name, " det unsigned"}, bus_u.out_det, eu);
        check({name, " det signed"}, bus_s.out_det, es);
        check({name, " zero flags"}, {bus_u.out_zero, bus_s.out_zero}, {eu == 15'd0, es == 15'd0});
        for (int t = 0; t < hold; t++) begin
            in_valid = 1'($urandom_range(1));
            in_data  = 4'($urandom_range(15));
            @(posedge clk); #1;
            check({name, " held result"},
                  {bus_u.out_valid, bus_u.in_ready, busy_u, bus_u.out_zero, bus_u.out_det},
                  {1'b1, 1'b0, 1'b1, eu == 15'd0, eu});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, " handshake"},
              {bus_u.out_valid, bus_u.in_ready, busy_u, bus_s.out_valid, bus_s.in_ready, busy_s},
              6'b010010);
        @(posedge clk); #1;
        check({name, " single handshake"}, {bus_u.out_valid, bus_s.out_valid}, 2'b00);
    endtask

    initial begin
        vec_t        tbl [8];
        logic [14:0] eu, es;
        mat_t        rm;

        tbl[0] = mv("diag 2 3 4",      mk(2,0,0, 0,3,0, 0,0,4),          1'b0, 15'd24,   0, 0);
        tbl[1] = mv("1..9 singular",   mk(1,2,3, 4,5,6, 7,8,9),          1'b0, 15'd0,    0, 0);
        tbl[2] = mv("swap rows",       mk(0,1,0, 1,0,0, 0,0,1),          1'b0, 15'h7FFF, 0, 0);
        tbl[3] = mv("max unsigned",    mk(15,15,0, 0,15,15, 15,0,15),    1'b0, 15'd6750, 0, 0);
        tbl[4] = mv("diag -8 signed",  mk(8,0,0, 0,8,0, 0,0,8),          1'b1, 15'h7E00, 0, 0);
        tbl[5] = mv("diag 1 2 3 gaps", mk(1,0,0, 0,2,0, 0,0,3),          1'b0, 15'd6,    40, 0);
        tbl[6] = mv("backpressure",    mk(3,1,4, 1,5,9, 2,6,5),          1'b0, 15'h7FA6, 0, 5);
        tbl[7] = mv("identity signed", mk(1,0,0, 0,1,0, 0,0,1),          1'b1, 15'd1,    0, 0);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset state unsigned",
              {bus_u.in_ready, bus_u.out_valid, bus_u.out_zero, busy_u, bus_u.out_det},
              {1'b1, 1'b0, 1'b0, 1'b0, 15'd0});
        check("reset state signed",
              {bus_s.in_ready, bus_s.out_valid, bus_s.out_zero, busy_s, bus_s.out_det},
              {1'b1, 1'b0, 1'b0, 1'b0, 15'd0});
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            eu = tbl[k].sgn ? model(tbl[k].m, 1'b0) : tbl[k].exp;
            es = tbl[k].sgn ? tbl[k].exp : model(tbl[k].m, 1'b1);
            do_one(tbl[k].name, tbl[k].m, eu, es, tbl[k].gap, tbl[k].hold);
        end

        // Abandon a partial load after four elements.
        out_ready = 1'b1;
        send(mk(3,3,3, 3,3,3, 3,3,3), 4, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset mid-load", {bus_u.in_ready, busy_u, bus_u.out_valid}, 3'b100);
        rst = 1'b0;
        do_one("diag 5 after load reset", mk(5,0,0, 0,5,0, 0,0,5), 15'd125, 15'd125, 0, 0);

        // Abandon a calculation at step 4.
        send(mk(7,2,9, 4,4,1, 6,3,8), 9, 0);
        repeat (4) @(posedge clk);
        #1;
        check("in calc before reset", {busy_u, bus_u.in_ready, bus_u.out_valid}, 3'b100);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset mid-calc",
              {busy_u, bus_u.in_ready, bus_u.out_valid, busy_s, bus_s.in_ready, bus_s.out_valid},
              6'b010010);
        rst = 1'b0;
        do_one("identity after calc reset", mk(1,0,0, 0,1,0, 0,0,1), 15'd1, 15'd1, 0, 0);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 9; k++) rm[k] = 4'($urandom_range(15));
            do_one("random", rm, model(rm, 1'b0), model(rm, 1'b1),
                   ($urandom_range(1) == 1) ? 30 : 0, int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
